// File: rtl/pb_uart_tx.sv
// PicoBlaze output-port UART transmitter: port decode, byte FIFO, 8N1 serialiser.
// A status byte is returned on in_port so firmware can poll for space and overflow.
module pb_uart_tx #(
    parameter int unsigned CLK_DIV        = 16,
    parameter logic [7:0]  TX_PORT_ID     = 8'h01,
    parameter logic [7:0]  STATUS_PORT_ID = 8'h02,
    parameter int unsigned DEPTH_LOG2     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(CLK_DIV);

    localparam logic [TW-1:0] TMAX     = TW'(CLK_DIV - 1);
    localparam logic [PW-1:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [7:0]    r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_clr;
    logic w_tick;
    logic w_active;

    assign w_empty    = (r_wr == r_rd);
    assign w_full     = ((r_wr ^ r_rd) == FULL_XOR);
    assign w_push_req = write_strobe && (port_id == TX_PORT_ID);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_clr      = read_strobe && (port_id == STATUS_PORT_ID);
    assign w_tick     = (r_timer == TMAX);
    assign w_active   = (r_state != S_IDLE);

    assign tx   = r_tx;
    assign busy = !w_empty || w_active;

    always_comb begin
        in_port = 8'h00;
        if (port_id == STATUS_PORT_ID) begin
            in_port = {4'b0000, r_ovf, w_active, w_full, w_empty};
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr[PW-2:0]] <= out_port;
        end
    end

    // Overflow set wins over a same-cycle clear by the status read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd[PW-2:0]];
                        r_timer <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line is driven from a register, so it trails the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx <= 1'b1;
        end else begin
            unique case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_uart_tx.sv
// Randomised bench for pb_uart_tx against a queue-based frame-timing model.
// Line, busy and status byte are compared every cycle.
module tb_pb_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] pid;
    logic       ws;
    logic [7:0] op;
    logic       rs;
    logic [7:0] in_port;
    logic       tx;
    logic       busy;

    int errors;
    int checks;

    logic [7:0] mq [$];
    logic [7:0] cur;
    logic       ovf;
    int         n;
    int         last_pop;
    int         idle_edge;
    logic [7:0] rd_val;

    pb_uart_tx #(
        .CLK_DIV       (C),
        .TX_PORT_ID    (8'h01),
        .STATUS_PORT_ID(8'h02),
        .DEPTH_LOG2    (3)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .port_id     (pid),
        .write_strobe(ws),
        .out_port    (op),
        .read_strobe (rs),
        .in_port     (in_port),
        .tx          (tx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, n);
        end
    endtask

    function automatic logic active_m();
        int d;
        d = n - last_pop;
        return (d >= 0) && (d < 10 * C);
    endfunction

    // Line after edge n: start (d=1..C), bits, stop, otherwise idle high.
    function automatic logic tx_m();
        int d;
        d = n - last_pop;
        if (d >= 1 && d <= C) return 1'b0;
        if (d > C && d <= 9 * C) return cur[(d - 1) / C - 1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] status_m();
        logic e;
        logic f;
        e = (mq.size() == 0);
        f = (mq.size() == DEPTH);
        if (pid != 8'h02) return 8'h00;
        return {4'b0000, ovf, active_m(), f, e};
    endfunction

    task automatic model_edge();
        logic was_empty;
        logic was_full;
        logic push;
        n++;
        if (!rst_n) begin
            mq.delete();
            ovf       = 1'b0;
            idle_edge = n + 1;
            last_pop  = -100000;
        end else begin
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == DEPTH);
            push      = ws && (pid == 8'h01);
            if (n >= idle_edge && !was_empty) begin
                cur       = mq.pop_front();
                last_pop  = n;
                idle_edge = n + 10 * C + 1;
            end
            if (push && !was_full) mq.push_back(op);
            if (rs && pid == 8'h02) ovf = 1'b0;
            if (push && was_full) ovf = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tx", {7'b0, tx}, {7'b0, tx_m()});
        check("busy", {7'b0, busy}, {7'b0, (mq.size() != 0) || active_m()});
        check("in_port", in_port, status_m());
    endtask

    task automatic idle(int k);
        ws  = 1'b0;
        rs  = 1'b0;
        pid = 8'h02;
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic push(logic [7:0] b, logic [7:0] p);
        ws  = 1'b1;
        pid = p;
        op  = b;
        step();
        ws  = 1'b0;
        pid = 8'h02;
    endtask

    task automatic rd_status();
        rs  = 1'b1;
        pid = 8'h02;
        #1;
        rd_val = in_port;
        check("rd_status", in_port, status_m());
        step();
        rs = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        n         = 0;
        last_pop  = -100000;
        idle_edge = 0;
        ovf       = 1'b0;
        cur       = 8'h00;
        rst_n     = 1'b0;
        ws        = 1'b0;
        rs        = 1'b0;
        pid       = 8'h02;
        op        = 8'h00;
        #1;

        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        check("rst_status", in_port, 8'h01);
        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_busy", {7'b0, busy}, 8'h00);

        push(8'h55, 8'h01);
        step();
        check("lat_tx_hi", {7'b0, tx}, 8'h01);
        step();
        check("lat_tx_lo", {7'b0, tx}, 8'h00);
        idle(50);
        check("single_idle_busy", {7'b0, busy}, 8'h00);

        for (int i = 0; i < 9; i++) push(8'(i), 8'h01);
        idle(9 * (10 * C + 1) + 10);

        for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i), 8'h01);
        rd_status();
        check("ovf_set", {7'b0, rd_val[3]}, 8'h01);
        rd_status();
        check("ovf_clr", {7'b0, rd_val[3]}, 8'h00);
        idle(9 * (10 * C + 1) + 10);

        push(8'h77, 8'h03);
        idle(5);
        check("decode_empty", in_port, 8'h01);
        push(8'h3C, 8'h01);
        rd_status();
        idle(50);

        push(8'hA5, 8'h01);
        push(8'h5A, 8'h01);
        idle(1 + 4 * C + 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_tx", {7'b0, tx}, 8'h01);
        idle(60);
        check("midrst_status", in_port, 8'h01);

        for (int i = 0; i < 600; i++) begin
            ws    = ($urandom_range(0, 3) == 0);
            rs    = ($urandom_range(0, 7) == 0);
            op    = 8'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 3))
                0, 1:    pid = 8'h01;
                2:       pid = 8'h02;
                default: pid = 8'h03;
            endcase
            step();
        end
        rst_n = 1'b1;
        idle(9 * (10 * C + 1) + 10);
        check("final_busy", {7'b0, busy}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pb_uart_tx.md
Name: pb_uart_tx

Overview:
- Downstream consumer of the PicoBlaze processor's output port.
- Decodes OUTPUT writes to a transmit port ID and queues the bytes in a small FIFO.
- Serialises the queued bytes as 8N1 UART frames on `tx`.
- Returns a status byte on the processor's input port, so firmware can poll for space and detect overflow.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit. Legal range 2..65535.
- TX_PORT_ID, 8'h01: port_id value that pushes `out_port` into the FIFO.
- STATUS_PORT_ID, 8'h02: port_id value that selects the status byte on `in_port`.
- DEPTH_LOG2, 3: FIFO depth is 2**DEPTH_LOG2 entries (default 8).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  synchronous, active-low reset.
- port_id  input  8  processor port address.
- write_strobe  input  1  processor OUTPUT strobe, one cycle.
- out_port  input  8  processor output data.
- read_strobe  input  1  processor INPUT strobe, one cycle.
- in_port  output  8  status byte to the processor (combinational).
- tx  output  1  UART serial output, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (reset==0 at a rising edge):
  - FIFO emptied; overflow flag cleared; FSM to IDLE.
  - tx=1 and busy=0 from the following cycle.
  - A frame in progress is abandoned, with no completion of its stop bit.
- Push: write_strobe==1 and port_id==TX_PORT_ID.
  - If FIFO not full, out_port is written at the tail.
  - If full, the byte is dropped and the sticky overflow flag is set.
  - Fullness is evaluated before any same-cycle pop: a push on a full FIFO is dropped even if the FSM pops in that cycle.
  - Writes to any other port_id are ignored.
- FIFO: circular, read/write pointers DEPTH_LOG2+1 bits wide.
  - Empty when the pointers are equal.
  - Full when they differ only in the MSB.
  - Pointers wrap modulo 2**(DEPTH_LOG2+1).
  - Simultaneous push (not full) and pop keeps the count unchanged.
- Status byte: in_port = {4'b0, overflow, tx_active, full, empty} when port_id==STATUS_PORT_ID, else 8'h00.
  - tx_active = FSM not in IDLE.
  - read_strobe with port_id==STATUS_PORT_ID clears overflow at that edge.
  - An overflow set in the same cycle as the clear wins, i.e. the flag stays set.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO non-empty, load the head into the shift register, pop, clear the bit timer, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE.
- Timing:
  - Back-to-back frames have one idle cycle between the stop bit and the next start bit.
  - Frame period is 10*CLK_DIV+1 cycles.
- Latency: tx falls at the second rising edge after the rising edge that samples the push strobe, when the FSM is in IDLE with the FIFO empty.
- Bit timer: counts 0..CLK_DIV-1 and wraps at CLK_DIV-1 with a bit advance. Width is $clog2(CLK_DIV).
- busy = !empty || tx_active, registered from the state and pointers.

Test Plan:
- Reset, CLK_DIV=4: hold reset=0 for 3 cycles, then release -> tx=1, busy=0, in_port (status selected) = 8'h01.
- Single byte, CLK_DIV=4: push 8'h55 -> tx low 2 edges after the strobe; bits 1,0,1,0,1,0,1,0 each 4 cycles; stop high 4 cycles; busy low after STOP.
- Burst, DEPTH_LOG2=3, CLK_DIV=4: push 9 bytes 8'h00..8'h08 on consecutive strobes.
  - Expected: bytes 8'h00..8'h07 transmitted in order and 8'h08 dropped; overflow=1 during the burst.
  - Alternative: if the first pop precedes the 9th push, all 9 are sent and overflow stays 0. The bench checks against a reference model.
- Overflow clear: fill the FIFO, push once more, then read status -> in_port bit3=1 on that read; the next status read shows bit3=0.
- Port decode: push with port_id=8'h03 -> no frame, status empty=1. Push with TX_PORT_ID while port_id selects status on a read -> correct status byte.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hA5 -> tx=1 next cycle, FIFO empty, no further frames, status = 8'h01.
